// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store bus controller between the memory stage and the
// SRAM / UART / I2C data-side targets. One request in flight at a time.
// Target codes: 2'b00 SRAM, 2'b01 UART, 2'b10 I2C, 2'b11 unmapped.
// Optional build macro: LSU_MISALIGN_CHECK_EN (misaligned half/word accesses
// become errors instead of being performed as if aligned).
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_sel,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        sram_cs,
    output logic        uart_cs,
    output logic        i2c_cs,
    input  logic [31:0] sram_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] i2c_rdata,
    input  logic        uart_ready,
    input  logic        i2c_ready
);

    localparam logic [1:0] MEM_SEL_SRAM = 2'b00;
    localparam logic [1:0] MEM_SEL_UART = 2'b01;
    localparam logic [1:0] MEM_SEL_I2C  = 2'b10;
    localparam logic [1:0] MEM_SEL_NONE = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {IDLE, ACCESS, SRAM_RD, PWAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  sel_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Byte lane where the access starts; halves/words are forced aligned.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return 4'b0011 << off;
            SIZE_WORD: return 4'hF;
            default:   return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] write_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            SIZE_BYTE: return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   return sh;
        endcase
    endfunction

    logic       misaligned;
    logic       req_bad;
    logic [1:0] req_off;
    logic       is_sram, is_uart, is_i2c;
    logic       periph_ready;
    logic [31:0] periph_rdata;
    logic [8:0] cs_cycles;
    logic       timeout_hit;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_bad = (req_sel == MEM_SEL_NONE) || (req_size == SIZE_ILL) || misaligned;
    assign req_off = lane_offset(req_size, req_addr[1:0]);

    assign is_sram = (sel_q == MEM_SEL_SRAM);
    assign is_uart = (sel_q == MEM_SEL_UART);
    assign is_i2c  = (sel_q == MEM_SEL_I2C);

    // Only the selected peripheral's ready/data are ever looked at.
    assign periph_ready = is_uart ? uart_ready : (is_i2c ? i2c_ready : 1'b0);
    assign periph_rdata = is_uart ? uart_rdata : i2c_rdata;

    // Cycles the chip-select will have been high once the current one ends.
    assign cs_cycles   = {1'b0, cnt_q} + 9'd1;
    assign timeout_hit = (cs_cycles >= 9'(TIMEOUT_CYCLES));

    // Capture the accepted request; bus-side lanes/enables precomputed here.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the bus registers drive outputs directly, so they are reset to
        // give defined zeros; sequential state always uses <= to avoid races.
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            sel_q   <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (req_valid && req_ready) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            sel_q   <= req_sel;
            off_q   <= req_off;
            addr_q  <= {req_addr[31:2], 2'b00};
            wdata_q <= write_lanes(req_size, req_wdata);
            be_q    <= byte_enables(req_size, req_off);
        end
    end

    // FSM state, response data/flag and chip-select cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, chip-selects and response capture.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned (which would infer a latch).
        state_d   = state_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = '0;
        req_ready = 1'b0;
        sram_cs   = 1'b0;
        uart_cs   = 1'b0;
        i2c_cs    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    err_d   = req_bad;
                    rdata_d = '0;
                    state_d = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS, PWAIT: begin
                sram_cs = is_sram && (state_q == ACCESS);
                uart_cs = is_uart;
                i2c_cs  = is_i2c;
                if (is_sram) begin
                    state_d = we_q ? RESP : SRAM_RD;
                end else if (periph_ready) begin
                    if (!we_q) rdata_d = extend_load(periph_rdata, size_q, off_q, uns_q);
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cs_cycles[7:0];
                    state_d = PWAIT;
                end
            end
            SRAM_RD: begin
                rdata_d = extend_load(sram_rdata, size_q, off_q, uns_q);
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign bus_we    = we_q && (sram_cs || uart_cs || i2c_cs);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl (TIMEOUT_CYCLES = 8).
// The model predicts, per request, the cycle window of the chip-select and
// the response cycle/data from the access rules; a negedge compare process
// checks every output each cycle. Literal expectations pin key results.
module tb_lsu_bus_ctrl;

    localparam int T = 8;
    localparam logic [1:0] SEL_SRAM = 2'b00;
    localparam logic [1:0] SEL_UART = 2'b01;
    localparam logic [1:0] SEL_I2C  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  ready_at;   // cycle (1 = ACCESS) ready pulses; 0 = never
        logic        noise;      // hold the other peripheral's ready high
        logic        poke;       // present junk requests while busy
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size, req_sel;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we, sram_cs, uart_cs, i2c_cs;
    logic [31:0] sram_rdata, uart_rdata, i2c_rdata;
    logic        uart_ready, i2c_ready;

    int   n_checks = 0;
    int   n_err    = 0;
    txn_t cur;
    int   k = 0;
    bit   active = 1'b0;
    int   cs_cycles;
    int   rsp_seen_k;
    logic [31:0] last_rdata, last_wdata;
    logic [3:0]  last_be;
    logic        last_err;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_sel(req_sel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
        .sram_cs(sram_cs), .uart_cs(uart_cs), .i2c_cs(i2c_cs),
        .sram_rdata(sram_rdata), .uart_rdata(uart_rdata), .i2c_rdata(i2c_rdata),
        .uart_ready(uart_ready), .i2c_ready(i2c_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit is_bad(input txn_t t);
        bit b;
        b = (t.sel == SEL_NONE) || (t.size == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
        if (t.size == 2'b01 && t.addr[0]) b = 1'b1;
        if (t.size == 2'b10 && t.addr[1:0] != 2'b00) b = 1'b1;
`endif
        return b;
    endfunction

    function automatic bit is_periph(input txn_t t);
        return (t.sel == SEL_UART) || (t.sel == SEL_I2C);
    endfunction

    function automatic bit timed_out(input txn_t t);
        return !is_bad(t) && is_periph(t) && !(t.ready_at >= 1 && int'(t.ready_at) <= T);
    endfunction

    // Last cycle (relative to handshake) the chip-select is high; 0 = none.
    function automatic int cs_last(input txn_t t);
        if (is_bad(t)) return 0;
        if (!is_periph(t)) return 1;
        return timed_out(t) ? T : int'(t.ready_at);
    endfunction

    function automatic int rsp_k(input txn_t t);
        if (is_bad(t)) return 1;
        if (!is_periph(t)) return t.we ? 2 : 3;
        return cs_last(t) + 1;
    endfunction

    function automatic logic [3:0] exp_be(input txn_t t);
        case (t.size)
            2'b00:   return 4'(1 << t.addr[1:0]);
            2'b01:   return t.addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input txn_t t);
        case (t.size)
            2'b00:   return {24'b0, t.wdata[7:0]} * 32'h0101_0101;
            2'b01:   return {16'b0, t.wdata[15:0]} * 32'h0001_0001;
            default: return t.wdata;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata(input txn_t t);
        int unsigned sh;
        logic [31:0] v;
        if (t.we || is_bad(t) || timed_out(t)) return 32'h0;
        if (t.size == 2'b00)      sh = int'(t.addr[1:0]) * 8;
        else if (t.size == 2'b01) sh = t.addr[1] ? 16 : 0;
        else                      sh = 0;
        v = t.rdata >> sh;
        if (t.size == 2'b00) begin
            v = v & 32'hFF;
            if (!t.uns && v >= 32'd128) v = v - 32'd256;
        end else if (t.size == 2'b01) begin
            v = v & 32'hFFFF;
            if (!t.uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        bit   in_win;
        logic e_sram, e_uart, e_i2c, e_any, e_rsp, e_ready;
        if (active) begin
            in_win  = (k >= 1) && (k <= cs_last(cur));
            e_sram  = in_win && (cur.sel == SEL_SRAM);
            e_uart  = in_win && (cur.sel == SEL_UART);
            e_i2c   = in_win && (cur.sel == SEL_I2C);
            e_rsp   = (k == rsp_k(cur));
            e_ready = (k == 0);
        end else begin
            e_sram = 1'b0; e_uart = 1'b0; e_i2c = 1'b0;
            e_rsp  = 1'b0; e_ready = 1'b1;
        end
        e_any = e_sram || e_uart || e_i2c;
        check("req_ready", req_ready, e_ready);
        check("sram_cs", sram_cs, e_sram);
        check("uart_cs", uart_cs, e_uart);
        check("i2c_cs", i2c_cs, e_i2c);
        check("bus_we", bus_we, e_any && cur.we);
        check("rsp_valid", rsp_valid, e_rsp);
        if (e_any) begin
            check("bus_addr", bus_addr, cur.addr & 32'hFFFF_FFFC);
            check("bus_be", bus_be, exp_be(cur));
            if (cur.we) check("bus_wdata", bus_wdata, exp_wdata(cur));
        end
        if (e_rsp) begin
            check("rsp_err", rsp_err, is_bad(cur) || timed_out(cur));
            check("rsp_rdata", rsp_rdata, exp_rdata(cur));
        end
        if (sram_cs || uart_cs || i2c_cs) begin
            cs_cycles++;
            last_be    = bus_be;
            last_wdata = bus_wdata;
        end
        if (rsp_valid) begin
            rsp_seen_k = active ? k : 999;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
    end

    // ---------------- driver ----------------
    function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [1:0] sel, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [7:0] ready_at, input logic noise, input logic poke);
        txn_t t;
        t.we = we; t.size = size; t.uns = uns; t.sel = sel; t.addr = addr;
        t.wdata = wdata; t.rdata = rdata; t.ready_at = ready_at;
        t.noise = noise; t.poke = poke;
        return t;
    endfunction

    task automatic drive_targets(input int c);
        bit hit;
        hit = (cur.ready_at != 0) && (c == int'(cur.ready_at));
        sram_rdata = (cur.sel == SEL_SRAM) ? cur.rdata : ~cur.rdata;
        uart_rdata = (cur.sel == SEL_UART) ? cur.rdata : ~cur.rdata;
        i2c_rdata  = (cur.sel == SEL_I2C)  ? cur.rdata : ~cur.rdata;
        uart_ready = (cur.sel == SEL_UART) ? hit : cur.noise;
        i2c_ready  = (cur.sel == SEL_I2C)  ? hit : cur.noise;
    endtask

    task automatic begin_txn(input txn_t t);
        cur = t; k = 0; active = 1'b1;
        cs_cycles = 0; rsp_seen_k = -1;
        last_rdata = 'x; last_err = 1'bx; last_be = '0; last_wdata = '0;
        req_valid = 1'b1; req_we = t.we; req_size = t.size; req_unsigned = t.uns;
        req_sel = t.sel; req_addr = t.addr; req_wdata = t.wdata;
        drive_targets(0);
    endtask

    task automatic step();
        @(posedge clk); #1;
        k++;
        req_valid = cur.poke && (k < rsp_k(cur));
        if (req_valid) begin
            req_we = 1'b1; req_size = 2'b10; req_sel = SEL_SRAM;
            req_addr = 32'hFFFF_FFF0; req_wdata = 32'h1234_5678;
        end
        drive_targets(k);
    endtask

    task automatic finish_txn();
        @(posedge clk); #1;
        active = 1'b0; req_valid = 1'b0;
        uart_ready = 1'b0; i2c_ready = 1'b0;
    endtask

    task automatic run(input txn_t t);
        begin_txn(t);
        for (int c = 1; c <= rsp_k(t); c++) step();
        finish_txn();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_sel = 2'b00; req_wdata = '0;
        sram_rdata = '0; uart_rdata = '0; i2c_rdata = '0;
        uart_ready = 1'b0; i2c_ready = 1'b0;
        cur = '0;
        #3;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_cs", {sram_cs, uart_cs, i2c_cs}, 3'b000);
        check("reset_bus_we", bus_we, 1'b0);
        check("reset_bus_addr", bus_addr, 32'h0);
        check("reset_bus_wdata", bus_wdata, 32'h0);
        check("reset_bus_be", bus_be, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // SW 0xDEADBEEF to SRAM 0x10
        run(mk(1, 2'b10, 0, SEL_SRAM, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1, 0));
        check("sw_be", last_be, 4'hF);
        check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        check("sw_rsp_cycle", rsp_seen_k, 2);
        check("sw_err", last_err, 1'b0);

        // LB / LBU from SRAM 0x13, junk requests presented while busy
        run(mk(0, 2'b00, 0, SEL_SRAM, 32'h13, 32'h0, 32'h80FF_0000, 0, 0, 1));
        check("lb_be", last_be, 4'b1000);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        check("lb_rsp_cycle", rsp_seen_k, 3);
        run(mk(0, 2'b00, 1, SEL_SRAM, 32'h13, 32'h0, 32'h80FF_0000, 0, 1, 1));
        check("lbu_rdata", last_rdata, 32'h0000_0080);
        idle(1);

        // SB 0x41 to UART, ready 5 cycles after uart_cs rises
        run(mk(1, 2'b00, 0, SEL_UART, 32'h100, 32'h0000_0041, 32'h0, 6, 1, 1));
        check("sb_wdata", last_wdata, 32'h4141_4141);
        check("sb_be", last_be, 4'b0001);
        check("sb_cs_cycles", cs_cycles, 6);
        check("sb_rsp_cycle", rsp_seen_k, 7);

        // I2C load, ready stuck low (UART ready high is ignored) -> timeout
        run(mk(0, 2'b10, 0, SEL_I2C, 32'h200, 32'h0, 32'h7777_7777, 0, 1, 0));
        check("to_cs_cycles", cs_cycles, T);
        check("to_err", last_err, 1'b1);
        check("to_rdata", last_rdata, 32'h0);
        check("to_rsp_cycle", rsp_seen_k, T + 1);

        // Error requests: unmapped target, illegal size
        run(mk(0, 2'b10, 0, SEL_NONE, 32'h300, 32'h0, 32'h1111_1111, 0, 1, 0));
        check("unmapped_err", last_err, 1'b1);
        check("unmapped_rsp_cycle", rsp_seen_k, 1);
        check("unmapped_cs_cycles", cs_cycles, 0);
        run(mk(1, 2'b11, 0, SEL_SRAM, 32'h40, 32'hAAAA_AAAA, 32'h0, 0, 0, 0));
        check("badsize_err", last_err, 1'b1);
        check("badsize_cs_cycles", cs_cycles, 0);

        // Misaligned word/half (error or aligned, depending on the build)
        run(mk(0, 2'b10, 0, SEL_SRAM, 32'h2, 32'h0, 32'hCAFE_F00D, 0, 0, 0));
        run(mk(0, 2'b01, 1, SEL_SRAM, 32'h1B, 32'h0, 32'hABCD_0000, 0, 0, 0));

        // Aligned halves, signed and unsigned
        run(mk(0, 2'b01, 0, SEL_SRAM, 32'h1A, 32'h0, 32'h8001_7FFF, 0, 0, 0));
        check("lh_rdata", last_rdata, 32'hFFFF_8001);
        run(mk(0, 2'b01, 1, SEL_SRAM, 32'h18, 32'h0, 32'h8001_7FFF, 0, 0, 0));
        check("lhu_rdata", last_rdata, 32'h0000_7FFF);

        // SH to I2C, ready in the ACCESS cycle
        run(mk(1, 2'b01, 0, SEL_I2C, 32'h22, 32'h0000_BEEF, 32'h0, 1, 1, 0));
        check("sh_be", last_be, 4'b1100);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_rsp_cycle", rsp_seen_k, 2);

        // LB from UART byte 1, ready after two wait cycles
        run(mk(0, 2'b00, 0, SEL_UART, 32'h101, 32'h0, 32'h0000_F200, 3, 1, 1));
        check("uart_lb_rdata", last_rdata, 32'hFFFF_FFF2);
        idle(1);

        // Reset during PWAIT of a UART access
        begin_txn(mk(0, 2'b10, 0, SEL_UART, 32'h204, 32'h0, 32'h5555_AAAA, 0, 0, 0));
        for (int c = 1; c <= 3; c++) step();
        @(negedge clk); #2;
        rst = 1'b1; active = 1'b0; req_valid = 1'b0;
        uart_ready = 1'b0; i2c_ready = 1'b0;
        #1;
        check("rst_uart_cs", uart_cs, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_seen_k = -1;
        idle(3);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_no_rsp", rsp_seen_k, -1);

        // Back-to-back after reset; second one checks the counter restarted
        run(mk(0, 2'b10, 0, SEL_SRAM, 32'h4, 32'h0, 32'h1234_5678, 0, 0, 0));
        check("lw_rdata", last_rdata, 32'h1234_5678);
        run(mk(0, 2'b10, 0, SEL_I2C, 32'h208, 32'h0, 32'h0, 0, 0, 0));
        check("to2_cs_cycles", cs_cycles, T);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
